axi_clint: RTL and testbench
============================

AXI_CLINT -- requirements
Module: axi_clint

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0200_0000: base of the 64 KiB CLINT window.
REQ-002 The block SHALL have parameter PRESCALE, default 16'd1: number of clk cycles per mtime increment, used only under CLINT_PRESCALE_EN.
REQ-003 Port clk, input, 1: single clock for all logic.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 AW channel ports SHALL be: axi_aw_id in 4, axi_aw_addr in 32, axi_aw_len in 8, axi_aw_size in 3, axi_aw_burst in 2, axi_aw_valid in 1, axi_aw_ready out 1.
REQ-006 W channel ports SHALL be: axi_w_data in 64, axi_w_strb in 8, axi_w_last in 1, axi_w_valid in 1, axi_w_ready out 1.
REQ-007 B channel ports SHALL be: axi_b_id out 4, axi_b_resp out 2, axi_b_valid out 1, axi_b_ready in 1.
REQ-008 AR channel ports SHALL be: axi_ar_id in 4, axi_ar_addr in 32, axi_ar_len in 8, axi_ar_size in 3, axi_ar_burst in 2, axi_ar_valid in 1, axi_ar_ready out 1.
REQ-009 R channel ports SHALL be: axi_r_id out 4, axi_r_data out 64, axi_r_resp out 2, axi_r_last out 1, axi_r_valid out 1, axi_r_ready in 1.
REQ-010 Interrupt ports SHALL be: timer_intr out 1 (drives the core's timer_intr input); soft_intr out 1.

Function
REQ-011 Register offsets from BASE_ADDR SHALL be: msip 0x0000 (bit0 only, other bits read 0), mtimecmp 0x4000 (64b), mtime 0xBFF8 (64b); all other offsets are unmapped.
REQ-012 The FSM SHALL have states IDLE, RDATA, WDATA and WRESP.
REQ-013 In IDLE: axi_ar_ready = 1; axi_aw_ready = ~axi_ar_valid. When both valids are high, the read wins.
REQ-014 AR handshake SHALL latch id, addr, len and go to RDATA; the first R beat is valid the next cycle.
REQ-015 RDATA SHALL present one beat per axi_r_ready; the address increments by 8 per beat for INCR bursts and is held for FIXED bursts; r_last is set on beat len+1; after the last handshake the FSM returns to IDLE.
REQ-016 While r_valid=1 and r_ready=0, r_data, r_resp and r_last SHALL stay stable.
REQ-017 AW handshake SHALL latch id, addr, len and go to WDATA, where axi_w_ready = 1.
REQ-018 Each W beat SHALL update the addressed register bytewise per axi_w_strb; the address steps as in REQ-015; w_last goes to WRESP.
REQ-019 WRESP SHALL hold b_valid = 1, b_id = latched id, until b_ready, then go to IDLE.
REQ-020 An unmapped beat SHALL read data 0 with resp 2'b10 (SLVERR); an unmapped write beat is discarded and the sticky error makes b_resp 2'b10; otherwise resp = 2'b00.
REQ-021 mtime SHALL increment by 1 per tick with 64-bit wrap from all-ones to 0; a bus write to mtime in the same cycle as a tick wins (no increment that cycle).
REQ-022 timer_intr SHALL be registered and equal (mtime >= mtimecmp, unsigned), updated one cycle after either operand changes.
REQ-023 soft_intr SHALL equal msip[0].
REQ-024 axi_ar_size and axi_aw_size SHALL be ignored; every beat is treated as 64-bit.

Reset
REQ-025 Asserting rst in any state SHALL immediately force IDLE and drop all in-flight transactions without a response.
REQ-026 Reset values SHALL be: mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0, timer_intr = 0.
REQ-027 Reset values SHALL be: all valid and ready outputs 0 (ar/aw ready rise after rst release per REQ-013); ids, data, resp and last = 0.

Configuration
REQ-028 With macro CLINT_PRESCALE_EN defined, a 16-bit prescaler SHALL produce one tick every PRESCALE cycles, with PRESCALE = 0 treated as 1; the prescaler resets to 0.
REQ-029 Without CLINT_PRESCALE_EN, a tick SHALL occur every clk cycle and the PRESCALE parameter is unused.

Structure
REQ-030 The shared AXI package SHALL hold: resp codes OKAY/SLVERR, burst encodings FIXED/INCR, CLINT offsets, and the FSM state typedef.
REQ-031 One sub-module clint_regs SHALL contain msip, mtime, mtimecmp, the prescaler and the compare, with a byte-strobed write port and a read-mux port; the AXI FSM sits in axi_clint.

Verification
REQ-032 Read 0xBFF8, len 0, 10 cycles after reset, no prescale -> r_data is approximately 10 (match the exact cycle count), r_resp 0, r_last 1, r_id echoed.
REQ-033 Write mtimecmp = 20, strb FF -> b_resp 0; timer_intr rises exactly one cycle after mtime reaches 20; writing mtimecmp = all-ones clears it.
REQ-034 INCR len 1 write at 0x4000, strb 0F then F0 -> second beat hits 0x4008 (unmapped), so b_resp 2'b10 and mtimecmp low word updated.
REQ-035 ar_valid and aw_valid asserted in the same cycle -> AR accepted first, aw_ready 0 until the read completes; r_ready held low for 5 cycles -> R outputs stable.
REQ-036 Write mtime = 64'hFFFF_FFFF_FFFF_FFFE -> wraps to 0 two ticks later; rst pulse mid-burst -> outputs match REQ-026/027 and the next transaction completes normally.
REQ-037 With CLINT_PRESCALE_EN and PRESCALE = 4 -> mtime advances once per 4 cycles.

Source files
------------

// File: rtl/axi_clint_pkg.sv
// axi_clint_pkg: shared constants and types for the AXI CLINT slice.
//   - AXI response codes and burst encodings
//   - CLINT register offsets within the 64 KiB window
//   - bus FSM state type, register select type, byte-merge and decode helpers
package axi_clint_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [15:0] OFF_MSIP     = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP = 16'h4000;
  localparam logic [15:0] OFF_MTIME    = 16'hBFF8;

  typedef enum logic [1:0] {IDLE, RDATA, WDATA, WRESP} state_t;

  typedef enum logic [1:0] {SEL_NONE, SEL_MSIP, SEL_MTIMECMP, SEL_MTIME} reg_sel_t;

  // Every beat is 64-bit, so the low three offset bits do not take part.
  function automatic reg_sel_t decode_off(input logic [15:0] off);
    reg_sel_t s;
    s = SEL_NONE;
    if (off[15:3] == OFF_MSIP[15:3])     s = SEL_MSIP;
    if (off[15:3] == OFF_MTIMECMP[15:3]) s = SEL_MTIMECMP;
    if (off[15:3] == OFF_MTIME[15:3])    s = SEL_MTIME;
    return s;
  endfunction

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  strb);
    logic [63:0] r;
    r = old_v;
    for (int i = 0; i < 8; i++)
      if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    return r;
  endfunction

  // FIXED holds the address; anything else steps by one 64-bit beat.
  function automatic logic [31:0] next_beat_addr(input logic [31:0] a, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? a : a + 32'd8;
  endfunction

endpackage

// File: rtl/clint_regs.sv
// clint_regs: CLINT register file (msip, mtime, mtimecmp), tick prescaler and
// timer compare.
//   clk, rst                 : clock, async active-high reset
//   wr_en/wr_off/wr_data/wr_strb : byte-strobed write port (offset in window)
//   wr_hit                   : wr_off maps to a register
//   rd_off/rd_data/rd_hit    : combinational read mux (0 when unmapped)
//   timer_intr               : registered mtime >= mtimecmp
//   soft_intr                : msip bit 0
// Macro CLINT_PRESCALE_EN: tick every PRESCALE cycles (0 treated as 1);
// otherwise mtime ticks every cycle.
module clint_regs
  import axi_clint_pkg::*;
#(
  parameter logic [15:0] PRESCALE = 16'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] wr_off,
  input  logic [63:0] wr_data,
  input  logic [7:0]  wr_strb,
  output logic        wr_hit,
  input  logic [15:0] rd_off,
  output logic [63:0] rd_data,
  output logic        rd_hit,
  output logic        timer_intr,
  output logic        soft_intr
);

  logic        msip;
  logic [63:0] mtime, mtimecmp;
  logic        tick;
  reg_sel_t    wsel, rsel;

  assign wsel      = decode_off(wr_off);
  assign rsel      = decode_off(rd_off);
  assign wr_hit    = (wsel != SEL_NONE);
  assign rd_hit    = (rsel != SEL_NONE);
  assign soft_intr = msip;

  always_comb begin
    rd_data = 64'd0;
    case (rsel)
      SEL_MSIP:     rd_data = {63'd0, msip};
      SEL_MTIMECMP: rd_data = mtimecmp;
      SEL_MTIME:    rd_data = mtime;
      default:      rd_data = 64'd0;
    endcase
  end

`ifdef CLINT_PRESCALE_EN
  localparam logic [15:0] DIV = (PRESCALE == 16'd0) ? 16'd1 : PRESCALE;
  logic [15:0] pre_cnt;

  assign tick = (pre_cnt == DIV - 16'd1);

  always_ff @(posedge clk or posedge rst)
    if (rst)       pre_cnt <= 16'd0;
    else if (tick) pre_cnt <= 16'd0;
    else           pre_cnt <= pre_cnt + 16'd1;
`else
  logic unused_prescale;
  assign unused_prescale = ^PRESCALE;
  assign tick = 1'b1;
`endif

  logic unused_off_lo;
  assign unused_off_lo = ^{wr_off[2:0], rd_off[2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msip       <= 1'b0;
      mtime      <= 64'd0;
      mtimecmp   <= '1;
      timer_intr <= 1'b0;
    end else begin
      if (wr_en && wsel == SEL_MSIP && wr_strb[0]) msip <= wr_data[0];
      if (wr_en && wsel == SEL_MTIMECMP) mtimecmp <= merge_bytes(mtimecmp, wr_data, wr_strb);
      // A bus write to mtime replaces that cycle's tick.
      if (wr_en && wsel == SEL_MTIME) mtime <= merge_bytes(mtime, wr_data, wr_strb);
      else if (tick)                  mtime <= mtime + 64'd1;
      timer_intr <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: rtl/axi_clint.sv
// axi_clint: AXI4 slave front-end for a RISC-V CLINT (msip/mtimecmp/mtime).
//   clk, rst      : clock, async active-high reset
//   axi_aw_*/axi_w_*/axi_b_* : write address/data/response channels
//   axi_ar_*/axi_r_*         : read address/data channels
//   timer_intr, soft_intr    : interrupt outputs
// One transaction at a time; read wins when AR and AW arrive together.
// Sizes are ignored (every beat is 64-bit). Macro CLINT_PRESCALE_EN enables
// the mtime prescaler (see clint_regs).
module axi_clint
  import axi_clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter logic [15:0] PRESCALE  = 16'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  axi_aw_id,
  input  logic [31:0] axi_aw_addr,
  input  logic [7:0]  axi_aw_len,
  input  logic [2:0]  axi_aw_size,
  input  logic [1:0]  axi_aw_burst,
  input  logic        axi_aw_valid,
  output logic        axi_aw_ready,
  input  logic [63:0] axi_w_data,
  input  logic [7:0]  axi_w_strb,
  input  logic        axi_w_last,
  input  logic        axi_w_valid,
  output logic        axi_w_ready,
  output logic [3:0]  axi_b_id,
  output logic [1:0]  axi_b_resp,
  output logic        axi_b_valid,
  input  logic        axi_b_ready,
  input  logic [3:0]  axi_ar_id,
  input  logic [31:0] axi_ar_addr,
  input  logic [7:0]  axi_ar_len,
  input  logic [2:0]  axi_ar_size,
  input  logic [1:0]  axi_ar_burst,
  input  logic        axi_ar_valid,
  output logic        axi_ar_ready,
  output logic [3:0]  axi_r_id,
  output logic [63:0] axi_r_data,
  output logic [1:0]  axi_r_resp,
  output logic        axi_r_last,
  output logic        axi_r_valid,
  input  logic        axi_r_ready,
  output logic        timer_intr,
  output logic        soft_intr
);

  state_t      state;
  logic        idle_rdy;  // held low in reset so ready rises only after release
  logic [31:0] addr, nxt_addr, rd_addr;
  logic [7:0]  len, beat;
  logic [1:0]  burst;
  logic        err;
  logic [63:0] rd_data;
  logic        rd_hit, rd_ok, wr_hit, wr_win, wr_ok, w_hs;

  logic unused_size;
  assign unused_size = ^{axi_ar_size, axi_aw_size};

  assign nxt_addr = next_beat_addr(addr, burst);
  // In IDLE the mux looks at the incoming AR so the first beat is ready at once;
  // in RDATA it looks ahead at the next beat's address.
  assign rd_addr  = (state == IDLE) ? axi_ar_addr : nxt_addr;
  assign rd_ok    = (rd_addr[31:16] == BASE_ADDR[31:16]) && rd_hit;
  assign wr_win   = (addr[31:16] == BASE_ADDR[31:16]);
  assign wr_ok    = wr_win && wr_hit;
  assign w_hs     = (state == WDATA) && axi_w_valid && axi_w_ready;

  assign axi_ar_ready = idle_rdy;
  assign axi_aw_ready = idle_rdy && !axi_ar_valid;

  clint_regs #(.PRESCALE(PRESCALE)) u_regs (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (w_hs && wr_win),
    .wr_off     (addr[15:0]),
    .wr_data    (axi_w_data),
    .wr_strb    (axi_w_strb),
    .wr_hit     (wr_hit),
    .rd_off     (rd_addr[15:0]),
    .rd_data    (rd_data),
    .rd_hit     (rd_hit),
    .timer_intr (timer_intr),
    .soft_intr  (soft_intr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idle_rdy    <= 1'b0;
      addr        <= 32'd0;
      len         <= 8'd0;
      beat        <= 8'd0;
      burst       <= 2'd0;
      err         <= 1'b0;
      axi_w_ready <= 1'b0;
      axi_b_valid <= 1'b0;
      axi_b_id    <= 4'd0;
      axi_b_resp  <= 2'd0;
      axi_r_valid <= 1'b0;
      axi_r_id    <= 4'd0;
      axi_r_data  <= 64'd0;
      axi_r_resp  <= 2'd0;
      axi_r_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          idle_rdy <= 1'b1;
          if (idle_rdy && axi_ar_valid) begin
            state       <= RDATA;
            idle_rdy    <= 1'b0;
            addr        <= axi_ar_addr;
            len         <= axi_ar_len;
            burst       <= axi_ar_burst;
            beat        <= 8'd0;
            axi_r_valid <= 1'b1;
            axi_r_id    <= axi_ar_id;
            axi_r_data  <= rd_ok ? rd_data : 64'd0;
            axi_r_resp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            axi_r_last  <= (axi_ar_len == 8'd0);
          end else if (idle_rdy && axi_aw_valid) begin
            state       <= WDATA;
            idle_rdy    <= 1'b0;
            addr        <= axi_aw_addr;
            len         <= axi_aw_len;
            burst       <= axi_aw_burst;
            axi_b_id    <= axi_aw_id;
            err         <= 1'b0;
            axi_w_ready <= 1'b1;
          end
        end
        RDATA: if (axi_r_ready) begin
          if (axi_r_last) begin
            state       <= IDLE;
            idle_rdy    <= 1'b1;
            axi_r_valid <= 1'b0;
            axi_r_last  <= 1'b0;
          end else begin
            addr       <= nxt_addr;
            beat       <= beat + 8'd1;
            axi_r_data <= rd_ok ? rd_data : 64'd0;
            axi_r_resp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            axi_r_last <= (beat + 8'd1 == len);
          end
        end
        WDATA: if (w_hs) begin
          addr <= nxt_addr;
          if (!wr_ok) err <= 1'b1;
          if (axi_w_last) begin
            state       <= WRESP;
            axi_w_ready <= 1'b0;
            axi_b_valid <= 1'b1;
            axi_b_resp  <= (err || !wr_ok) ? RESP_SLVERR : RESP_OKAY;
          end
        end
        WRESP: if (axi_b_ready) begin
          state       <= IDLE;
          idle_rdy    <= 1'b1;
          axi_b_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_clint.sv
// tb_axi_clint: directed bench for axi_clint with a register-level model of the
// CLINT (mtime counter, mtimecmp, msip, registered compare) that is checked
// against the interrupt outputs every cycle and against every read beat.
module tb_axi_clint;
  import axi_clint_pkg::*;

`ifdef CLINT_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk, rst;
  logic [3:0]  axi_aw_id;    logic [31:0] axi_aw_addr; logic [7:0] axi_aw_len;
  logic [2:0]  axi_aw_size;  logic [1:0]  axi_aw_burst; logic axi_aw_valid, axi_aw_ready;
  logic [63:0] axi_w_data;   logic [7:0]  axi_w_strb;
  logic        axi_w_last, axi_w_valid, axi_w_ready;
  logic [3:0]  axi_b_id;     logic [1:0]  axi_b_resp;  logic axi_b_valid, axi_b_ready;
  logic [3:0]  axi_ar_id;    logic [31:0] axi_ar_addr; logic [7:0] axi_ar_len;
  logic [2:0]  axi_ar_size;  logic [1:0]  axi_ar_burst; logic axi_ar_valid, axi_ar_ready;
  logic [3:0]  axi_r_id;     logic [63:0] axi_r_data;  logic [1:0] axi_r_resp;
  logic        axi_r_last, axi_r_valid, axi_r_ready;
  logic        timer_intr, soft_intr;

  axi_clint #(.BASE_ADDR(BASE), .PRESCALE(16'(P))) dut (
    .clk(clk), .rst(rst),
    .axi_aw_id(axi_aw_id), .axi_aw_addr(axi_aw_addr), .axi_aw_len(axi_aw_len),
    .axi_aw_size(axi_aw_size), .axi_aw_burst(axi_aw_burst), .axi_aw_valid(axi_aw_valid),
    .axi_aw_ready(axi_aw_ready),
    .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
    .axi_b_id(axi_b_id), .axi_b_resp(axi_b_resp), .axi_b_valid(axi_b_valid),
    .axi_b_ready(axi_b_ready),
    .axi_ar_id(axi_ar_id), .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len),
    .axi_ar_size(axi_ar_size), .axi_ar_burst(axi_ar_burst), .axi_ar_valid(axi_ar_valid),
    .axi_ar_ready(axi_ar_ready),
    .axi_r_id(axi_r_id), .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp),
    .axi_r_last(axi_r_last), .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready),
    .timer_intr(timer_intr), .soft_intr(soft_intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip, m_tint, m_nx, m_tick;
  int          m_n;
  logic [31:0] m_wa;  // address of the W beat currently offered

  function automatic logic [63:0] bmerge(input logic [63:0] o, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // 0 unmapped, 1 msip, 2 mtimecmp, 3 mtime
  function automatic int m_kind(input logic [31:0] a);
    logic [31:0] al;
    al = {a[31:3], 3'b000};
    if (al == BASE)              return 1;
    if (al == BASE + 32'h4000)   return 2;
    if (al == BASE + 32'hBFF8)   return 3;
    return 0;
  endfunction

  function automatic logic [63:0] m_read(input logic [31:0] a);
    case (m_kind(a))
      1: return {63'd0, m_msip};
      2: return m_cmp;
      3: return m_mtime;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [1:0] m_resp(input logic [31:0] a);
    return (m_kind(a) == 0) ? 2'b10 : 2'b00;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mtime = 64'd0; m_cmp = '1; m_msip = 1'b0; m_tint = 1'b0; m_n = 0;
    end else begin
      m_nx   = (m_mtime >= m_cmp);
      m_n    = m_n + 1;
      m_tick = ((m_n % P) == 0);
      if (axi_w_valid && axi_w_ready && m_kind(m_wa) == 3)
        m_mtime = bmerge(m_mtime, axi_w_data, axi_w_strb);
      else if (m_tick)
        m_mtime = m_mtime + 64'd1;
      if (axi_w_valid && axi_w_ready && m_kind(m_wa) == 2)
        m_cmp = bmerge(m_cmp, axi_w_data, axi_w_strb);
      if (axi_w_valid && axi_w_ready && m_kind(m_wa) == 1 && axi_w_strb[0])
        m_msip = axi_w_data[0];
      m_tint = m_nx;
    end
  end

  // Interrupt outputs follow the model on every cycle.
  always @(negedge clk) begin
    chk("timer_intr", timer_intr, m_tint);
    chk("soft_intr", soft_intr, m_msip);
  end

  // ---------------- stimulus ----------------
  logic [63:0] last_rdata;

  task automatic rd(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                    input logic [1:0] burst, input int stall);
    logic [63:0] ed; logic [1:0] er; int t;
    axi_ar_id = id; axi_ar_addr = a; axi_ar_len = len; axi_ar_burst = burst;
    axi_ar_size = 3'd3; axi_ar_valid = 1'b1;
    #1;
    if (axi_aw_valid) chk("aw_blocked_by_ar", axi_aw_ready, 0);
    t = 0;
    while (!axi_ar_ready && t < 20) begin @(negedge clk); #1; t++; end
    chk("ar_ready_wait", 64'(t < 20), 1);
    ed = m_read(a); er = m_resp(a);
    @(negedge clk); axi_ar_valid = 1'b0; #1;
    for (int b = 0; b <= int'(len); b++) begin
      chk("r_valid", axi_r_valid, 1);
      chk("r_data", axi_r_data, ed);
      chk("r_resp", axi_r_resp, er);
      chk("r_last", axi_r_last, 64'(b == int'(len)));
      chk("r_id", axi_r_id, id);
      if (b == 0) last_rdata = axi_r_data;
      for (int s = 0; s < stall && b == 0; s++) begin
        @(negedge clk); #1;
        chk("r_stall_valid", axi_r_valid, 1);
        chk("r_stall_data", axi_r_data, ed);
        chk("r_stall_resp", axi_r_resp, er);
        chk("r_stall_last", axi_r_last, 64'(int'(len) == 0));
        if (axi_aw_valid) chk("aw_blocked_in_read", axi_aw_ready, 0);
      end
      axi_r_ready = 1'b1;
      a  = next_beat_addr(a, burst);
      ed = m_read(a); er = m_resp(a);
      @(negedge clk); axi_r_ready = 1'b0; #1;
      if (axi_aw_valid && b < int'(len)) chk("aw_blocked_in_read", axi_aw_ready, 0);
    end
    chk("r_done", axi_r_valid, 0);
  endtask

  task automatic wr(input logic [3:0] id, input logic [31:0] a, input logic [1:0] burst,
                    input logic [63:0] d0, input logic [7:0] s0,
                    input logic [63:0] d1, input logic [7:0] s1,
                    input int nb, input logic [1:0] eresp);
    int t;
    axi_aw_id = id; axi_aw_addr = a; axi_aw_len = 8'(nb - 1); axi_aw_burst = burst;
    axi_aw_size = 3'd3; axi_aw_valid = 1'b1;
    #1;
    t = 0;
    while (!axi_aw_ready && t < 20) begin @(negedge clk); #1; t++; end
    chk("aw_ready_wait", 64'(t < 20), 1);
    @(negedge clk); axi_aw_valid = 1'b0;
    for (int b = 0; b < nb; b++) begin
      axi_w_data = (b == 0) ? d0 : d1;
      axi_w_strb = (b == 0) ? s0 : s1;
      axi_w_last = (b == nb - 1);
      axi_w_valid = 1'b1;
      m_wa = a;
      #1;
      t = 0;
      while (!axi_w_ready && t < 20) begin @(negedge clk); #1; t++; end
      chk("w_ready_wait", 64'(t < 20), 1);
      @(negedge clk);
      a = next_beat_addr(a, burst);
    end
    axi_w_valid = 1'b0; axi_w_last = 1'b0; #1;
    chk("b_valid", axi_b_valid, 1);
    chk("b_resp", axi_b_resp, eresp);
    chk("b_id", axi_b_id, id);
    axi_b_ready = 1'b1;
    @(negedge clk); axi_b_ready = 1'b0; #1;
    chk("b_done", axi_b_valid, 0);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    axi_aw_id = 0; axi_aw_addr = 0; axi_aw_len = 0; axi_aw_size = 0; axi_aw_burst = 0; axi_aw_valid = 0;
    axi_w_data = 0; axi_w_strb = 0; axi_w_last = 0; axi_w_valid = 0; axi_b_ready = 0;
    axi_ar_id = 0; axi_ar_addr = 0; axi_ar_len = 0; axi_ar_size = 0; axi_ar_burst = 0; axi_ar_valid = 0;
    axi_r_ready = 0; m_wa = 0; last_rdata = 0;
    repeat (3) @(negedge clk); #1;
    chk("rst_ar_ready", axi_ar_ready, 0);
    chk("rst_aw_ready", axi_aw_ready, 0);
    chk("rst_w_ready", axi_w_ready, 0);
    chk("rst_r_valid", axi_r_valid, 0);
    chk("rst_b_valid", axi_b_valid, 0);
    chk("rst_r_bus", {axi_r_data[59:0], axi_r_id}, 0);
    chk("rst_r_misc", {axi_r_resp, axi_r_last, axi_b_id, axi_b_resp}, 0);
    chk("rst_timer", timer_intr, 0);
    rst = 1'b0;

    // mtime read 10 cycles after reset release
    repeat (10) @(negedge clk);
    rd(4'h5, BASE + 32'hBFF8, 8'd0, BURST_INCR, 0);
    chk("mtime_after_10", last_rdata, 64'(10 / P));

    // simultaneous AR/AW: read first, stalled R, then the write to msip
    axi_aw_id = 4'h3; axi_aw_addr = BASE; axi_aw_len = 0; axi_aw_burst = BURST_INCR; axi_aw_valid = 1'b1;
    rd(4'h9, BASE + 32'hBFF8, 8'd1, BURST_INCR, 5);
    wr(4'h3, BASE, BURST_INCR, 64'h1, 8'h01, 64'h0, 8'h00, 1, RESP_OKAY);
    chk("soft_intr_set", soft_intr, 1);
    rd(4'h2, BASE, 8'd2, BURST_FIXED, 0);
    chk("msip_read", last_rdata, 64'h1);
    rd(4'h4, 32'h1000_0000, 8'd0, BURST_INCR, 0);
    chk("outside_window", last_rdata, 64'h0);

    // timer compare edge
    wr(4'h1, BASE + 32'hBFF8, BURST_INCR, 64'd0, 8'hFF, 64'd0, 8'h00, 1, RESP_OKAY);
    wr(4'h1, BASE + 32'h4000, BURST_INCR, 64'd20, 8'hFF, 64'd0, 8'h00, 1, RESP_OKAY);
    t = 0;
    while (m_mtime != 64'd20 && t < 200) begin @(negedge clk); #1; t++; end
    chk("mtime_reach_20", 64'(t < 200), 1);
    chk("timer_before", timer_intr, 0);
    @(negedge clk); #1;
    chk("timer_rise", timer_intr, 1);
    wr(4'h1, BASE + 32'h4000, BURST_INCR, '1, 8'hFF, 64'd0, 8'h00, 1, RESP_OKAY);
    chk("timer_cleared", timer_intr, 0);

    // INCR burst straying into an unmapped offset
    wr(4'h7, BASE + 32'h4000, BURST_INCR, 64'h1111_2222_3333_4444, 8'h0F,
       64'h5555_6666_7777_8888, 8'hF0, 2, RESP_SLVERR);
    rd(4'h1, BASE + 32'h4000, 8'd0, BURST_INCR, 0);
    chk("mtimecmp_low", last_rdata, 64'hFFFF_FFFF_3333_4444);

    // mtime wrap
    wr(4'h6, BASE + 32'hBFF8, BURST_INCR, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 64'd0, 8'h00, 1, RESP_OKAY);
`ifndef CLINT_PRESCALE_EN
    chk("wrap_timer_fe", timer_intr, 1);
    @(negedge clk); #1;
    chk("wrap_timer_ff", timer_intr, 1);
    @(negedge clk); #1;
    chk("wrap_timer_0", timer_intr, 0);
    rd(4'h6, BASE + 32'hBFF8, 8'd0, BURST_INCR, 0);
    chk("mtime_wrapped", last_rdata, 64'd1);
`else
    repeat (3) @(negedge clk);
    rd(4'h6, BASE + 32'hBFF8, 8'd0, BURST_INCR, 0);
    begin
      logic [63:0] v0;
      v0 = last_rdata;
      repeat (8) @(negedge clk);
      rd(4'h6, BASE + 32'hBFF8, 8'd0, BURST_INCR, 0);
      chk("prescale_rate", last_rdata - v0, 64'd3);
    end
`endif

    // reset in the middle of a read burst
    @(negedge clk);
    axi_ar_id = 4'hA; axi_ar_addr = BASE + 32'h4000; axi_ar_len = 8'd3; axi_ar_burst = BURST_INCR;
    axi_ar_valid = 1'b1;
    @(negedge clk); axi_ar_valid = 1'b0; #1;
    chk("burst_started", axi_r_valid, 1);
    rst = 1'b1; #1;
    chk("midrst_r_valid", axi_r_valid, 0);
    chk("midrst_r_bus", {axi_r_data, axi_r_id, axi_r_resp, axi_r_last}, 0);
    chk("midrst_ready", {axi_ar_ready, axi_aw_ready, axi_w_ready, axi_b_valid}, 0);
    chk("midrst_intr", {timer_intr, soft_intr}, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("post_rst_ar_ready", axi_ar_ready, 0);
    @(negedge clk);
    wr(4'hB, BASE, BURST_INCR, 64'h1, 8'h01, 64'h0, 8'h00, 1, RESP_OKAY);
    rd(4'hC, BASE, 8'd0, BURST_INCR, 0);
    chk("post_rst_msip", last_rdata, 64'h1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
